// File: rtl/matmul_loader_ctrl.sv
// matmul_loader_ctrl: upstream sequencer for matrix_multiplier.
// Loads paired row/column elements into the ROW and COLUMN memories, then
// reads them back in order. It drives the MAC control strobes so they line up
// with the memory read latency and the accumulator latency.
module matmul_loader_ctrl #(
  parameter int In_W       = 32,
  parameter int In_D_Add_W = 4,
  parameter int In_Items   = 6,
  parameter int RD_LAT     = 1,
  parameter int MAC_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [In_W-1:0]       s_row,
  input  logic [In_W-1:0]       s_col,
  output logic                  ena_r,
  output logic                  wea_r,
  output logic                  ena_c,
  output logic                  wea_c,
  output logic [In_D_Add_W-1:0] addra_r,
  output logic [In_D_Add_W-1:0] addra_c,
  output logic [In_W-1:0]       din_r,
  output logic [In_W-1:0]       din_c,
  output logic                  enb_r,
  output logic                  enb_c,
  output logic [In_D_Add_W-1:0] addrb_r,
  output logic [In_D_Add_W-1:0] addrb_c,
  output logic                  clr,
  output logic                  en_MAC,
  output logic                  en_MAC_out,
  output logic                  busy,
  output logic                  done
);

  // Address of the last element. Both the write and the read counters stop here.
  localparam logic [In_D_Add_W-1:0] LAST_ADDR = In_D_Add_W'(In_Items - 1);

  // DRAIN covers the memory read latency plus the accumulator latency.
  localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
  localparam int DR_W      = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [In_D_Add_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [In_D_Add_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DR_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic                  clr_q, clr_d;
  logic [RD_LAT-1:0]     rd_pipe_q, rd_pipe_d;

  logic load_active;
  logic wr_fire;
  logic rd_active;

  // State register; an asynchronous reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, the registered clear pulse and the read-to-MAC delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      clr_q       <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      clr_q       <= clr_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  // Next-state logic. LOAD advances only on accepted pairs. READ and DRAIN run
  // for a fixed number of cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (wr_fire && (wr_cnt_q == LAST_ADDR)) state_d = S_READ;
      S_READ:  if (rd_cnt_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter updates. Each counter is cleared when it hands off to the next
  // phase, so the next transaction starts from zero.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    drain_cnt_d = drain_cnt_q;
    clr_d       = 1'b0;
    rd_pipe_d   = (rd_pipe_q << 1) | RD_LAT'(rd_active);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_d    = 1'b1;
          wr_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (wr_fire) begin
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_cnt_q == LAST_ADDR) begin
          rd_cnt_d    = '0;
          drain_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        wr_cnt_d = wr_cnt_q;
      end
    endcase
  end

  // Output decode. Write data and addresses are forced to zero outside LOAD so
  // that nothing reaches the memories while a reset is active.
  always_comb begin
    load_active = (state_q == S_LOAD);
    rd_active   = (state_q == S_READ);
    wr_fire     = s_valid && load_active;

    s_ready    = load_active;
    ena_r      = wr_fire;
    wea_r      = wr_fire;
    ena_c      = wr_fire;
    wea_c      = wr_fire;
    addra_r    = load_active ? wr_cnt_q : '0;
    addra_c    = load_active ? wr_cnt_q : '0;
    din_r      = load_active ? s_row : '0;
    din_c      = load_active ? s_col : '0;

    enb_r      = rd_active;
    enb_c      = rd_active;
    addrb_r    = rd_active ? rd_cnt_q : '0;
    addrb_c    = rd_active ? rd_cnt_q : '0;

    clr        = clr_q;
    en_MAC     = rd_pipe_q[RD_LAT-1];
    en_MAC_out = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_matmul_loader_ctrl.sv
// tb_matmul_loader_ctrl: directed and randomised transactions against
// matmul_loader_ctrl. A behavioural memory and MAC are attached, and the
// expected cycle timing and dot product are derived from the stimulus.
module tb_matmul_loader_ctrl;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int N  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_row;
  logic [W-1:0]  s_col;
  logic          ena_r, wea_r, ena_c, wea_c;
  logic [AW-1:0] addra_r, addra_c;
  logic [W-1:0]  din_r, din_c;
  logic          enb_r, enb_c;
  logic [AW-1:0] addrb_r, addrb_c;
  logic          clr, en_MAC, en_MAC_out, busy, done;

  int checks   = 0;
  int failures = 0;

  int rows [N];
  int cols [N];

  logic signed [W-1:0] row_mem [2**AW];
  logic signed [W-1:0] col_mem [2**AW];
  logic signed [W-1:0] dout_r, dout_c;
  longint acc;
  longint y;

  matmul_loader_ctrl #(
    .In_W(W), .In_D_Add_W(AW), .In_Items(N), .RD_LAT(1), .MAC_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_row(s_row), .s_col(s_col),
    .ena_r(ena_r), .wea_r(wea_r), .ena_c(ena_c), .wea_c(wea_c),
    .addra_r(addra_r), .addra_c(addra_c), .din_r(din_r), .din_c(din_c),
    .enb_r(enb_r), .enb_c(enb_c), .addrb_r(addrb_r), .addrb_c(addrb_c),
    .clr(clr), .en_MAC(en_MAC), .en_MAC_out(en_MAC_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in for the memories (1-cycle read) and the MAC (1-cycle accumulate).
  always @(posedge clk) begin
    if (ena_r && wea_r) row_mem[addra_r] <= din_r;
    if (ena_c && wea_c) col_mem[addra_c] <= din_c;
    if (enb_r) dout_r <= row_mem[addrb_r];
    if (enb_c) dout_c <= col_mem[addrb_c];
    if (clr) acc <= 0;
    else if (en_MAC) acc <= acc + longint'(dout_r) * longint'(dout_c);
    if (en_MAC_out) y <= acc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller is just after a posedge, in an IDLE cycle (cycle 0).
  // gap_mode: 0 none, 1 alternating starting with valid, 2 random.
  task automatic run_txn(input int gap_mode, input bit hold);
    int k, last, c, r;
    bit v;
    longint exp_y;
    exp_y = 0;
    for (int i = 0; i < N; i++) exp_y += longint'(rows[i]) * longint'(cols[i]);
    k = 0; last = -1; c = 0;
    start = 1'b1; s_valid = 1'($urandom); s_row = $urandom; s_col = $urandom;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 0);
    chk("idle_write", wea_r, 0);
    forever begin
      @(posedge clk); #1; c++;
      start = hold ? 1'b1 : 1'($urandom);
      if (last < 0) begin
        case (gap_mode)
          0: v = 1'b1;
          1: v = (c % 2) == 1;
          default: v = ($urandom % 3) != 0;
        endcase
        s_valid = v;
        s_row = v ? rows[k] : $urandom;
        s_col = v ? cols[k] : $urandom;
      end else begin
        s_valid = 1'($urandom); s_row = $urandom; s_col = $urandom;
      end
      @(negedge clk);
      if (last < 0) begin
        chk("load_ready", s_ready, 1);
        chk("load_wea_r", wea_r, v);
        chk("load_ena_c", ena_c, v);
        chk("load_clr", clr, c == 1);
        chk("load_busy", busy, 1);
        chk("load_enb", enb_r, 0);
        if (v) begin
          chk("load_addra_r", addra_r, k);
          chk("load_addra_c", addra_c, k);
          chk("load_din_r", din_r, $unsigned(rows[k]));
          chk("load_din_c", din_c, $unsigned(cols[k]));
          k++;
          if (k == N) last = c;
        end
      end else begin
        r = c - last;
        chk("post_ready", s_ready, 0);
        chk("post_write", wea_r | ena_c, 0);
        chk("post_clr", clr, 0);
        chk("rd_enb_r", enb_r, (r >= 1) && (r <= N));
        chk("rd_enb_c", enb_c, (r >= 1) && (r <= N));
        if (r <= N) begin
          chk("rd_addrb_r", addrb_r, r - 1);
          chk("rd_addrb_c", addrb_c, r - 1);
        end
        chk("en_mac", en_MAC, (r >= 2) && (r <= N + 1));
        chk("en_mac_out", en_MAC_out, r == N + 2);
        chk("done", done, r == N + 3);
        chk("busy", busy, 1);
        if (r == N + 3) begin
          chk("y_at_done", y, exp_y);
          break;
        end
      end
      if (c > 200) begin
        failures++;
        $error("[TB] FAIL timeout observed=%0d expected=done", c);
        break;
      end
    end
    @(posedge clk); #1;
    start = hold; s_valid = 1'b0;
  endtask

  initial begin
    // Power-on reset with inputs moving.
    rst = 1'b0; start = 1'b1; s_valid = 1'b1; s_row = 5; s_col = 7;
    #3;
    chk("por_busy", busy, 0);
    chk("por_ready", s_ready, 0);
    chk("por_clr", clr, 0);
    chk("por_enb", enb_r, 0);
    chk("por_done", done, 0);
    @(negedge clk); start = 1'b0; s_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-LOAD while start/s_valid toggle.
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    chk("mid_load_ready", s_ready, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_ready", s_ready, 0);
    chk("arst_write", wea_r, 0);
    chk("arst_addra", addra_r, 0);
    chk("arst_din", din_r, 0);
    chk("arst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; start = ~start; s_valid = ~s_valid;
      @(negedge clk);
      chk("arst_hold_busy", busy, 0);
    end
    start = 1'b0; s_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_arst_idle", busy, 0);
    @(posedge clk); #1;

    // Basic: 1..6 x 1..6 = 91.
    for (int i = 0; i < N; i++) begin rows[i] = i + 1; cols[i] = i + 1; end
    run_txn(0, 1'b0);
    // Signed: -1 x 2..7 = -27.
    for (int i = 0; i < N; i++) begin rows[i] = -1; cols[i] = i + 2; end
    run_txn(0, 1'b0);
    // Stalled input, alternating valid.
    for (int i = 0; i < N; i++) begin rows[i] = i + 1; cols[i] = i + 1; end
    run_txn(1, 1'b0);
    // Start held high across back-to-back transactions.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        rows[i] = int'($urandom_range(0, 2000)) - 1000;
        cols[i] = int'($urandom_range(0, 2000)) - 1000;
      end
      run_txn(2, t != 2);
    end
    // Random data with random gaps.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        rows[i] = int'($urandom);
        cols[i] = int'($urandom_range(0, 200)) - 100;
      end
      run_txn(2, 1'b0);
    end

    // Reset in the middle of READ (cycle 9).
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b1; s_row = c; s_col = c;
    end
    @(negedge clk);
    chk("mid_read_enb", enb_r, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rrst_enb", enb_r, 0);
    chk("rrst_en_mac", en_MAC, 0);
    chk("rrst_busy", busy, 0);
    chk("rrst_addrb", addrb_r, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rrst_en_mac_out", en_MAC_out, 0);
      chk("rrst_done", done, 0);
    end
    s_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rrel_done", done, 0);
      chk("rrel_busy", busy, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin rows[i] = 2; cols[i] = 3; end
    run_txn(0, 1'b0);
    @(negedge clk);
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
